div_share_arbiter: RTL and testbench
====================================

# div_share_arbiter

Round-robin arbiter and sequencer that shares one `sar_divisor_module` between several requesters in the pitch-detection datapath, such as the modified-difference normalisation and the average computation. It owns the divider's start pulse and operand registers, and returns each quotient to the requester that asked for it with a one-cycle done pulse. Sharing one divider lets several tau lanes normalise without instantiating a 64-bit SAR divider per lane.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..16).
- `BITS`, 64: operand and result width; must equal the divider's `BITS`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level.
- `dividendo_in`  in  NUM_REQ*BITS  packed dividends; requester i at bits [i*BITS +: BITS].
- `divisor_in`  in  NUM_REQ*BITS  packed divisors, same packing.
- `grant`  out  NUM_REQ  one-hot; the requester currently owning the divider.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse when the quotient is valid.
- `result`  out  BITS  last quotient; held until the next completion.
- `busy`  out  1  high whenever the state is not IDLE.
- `div_start`  out  1  drives the divider's `reset` (start) input.
- `div_dividendo`  out  BITS  divider dividend.
- `div_divisor`  out  BITS  divider divisor.
- `div_ready`  in  1  divider ready.
- `div_result`  in  BITS  divider quotient.

## Operation
- States: IDLE, LAUNCH, SETTLE, WAIT, DONE.
- Round-robin pointer `last`; its reset value is NUM_REQ-1, so requester 0 wins first. Search order is last+1, last+2, … with modulo NUM_REQ wrap.
- IDLE, any `req` bit set:
  - Select the winner w and set `last`=w, `grant`=1<<w.
  - Latch w's operands into `div_dividendo`/`div_divisor`.
  - Set `div_start`=1 and go to LAUNCH.
- LAUNCH: set `div_start`=0 and go to SETTLE. The start pulse is exactly one cycle wide.
- SETTLE: ignore `div_ready`, which may still be stale from the previous division. Go to WAIT.
- WAIT, `div_ready`=1:
  - Set `result`=`div_result` and `done`=`grant`.
  - Go to DONE.
- DONE:
  - The `done` pulse is visible for this cycle only.
  - On exit, `done`=0 and `grant`=0, and the state returns to IDLE.
- Operands stay latched for the whole operation. Changes on `dividendo_in`/`divisor_in`/`req` after grant have no effect on it.
- If the requester drops `req` mid-operation, the operation still completes and `done` still pulses.
- A requester must deassert `req` in the cycle after it sees `done`. A `req` still high in IDLE is treated as a new request, but it loses priority to every other pending requester.
- `div_dividendo`/`div_divisor` hold their last values in IDLE.

## Timing
- Reset (async, immediate): state IDLE; `grant`, `done`, `result`, `busy`, `div_start`, `div_dividendo`, `div_divisor` all 0; `last`=NUM_REQ-1.
- Reset mid-operation aborts the division. `div_start` drops without waiting for a clock edge, and no `done` pulse is issued.
- Cycle numbering, with the request sampled in IDLE at the edge ending cycle T:
  - T+1: `grant` and `busy` high, `div_start` high.
  - T+2: SETTLE.
  - T+3 onward: WAIT.
- If `div_ready` is first seen high in WAIT at cycle W, `done`/`result` are valid in cycle W+1 and IDLE is reached at W+2.
- Back-to-back minimum spacing between two grants is 5 cycles plus the divider's latency.
- Simultaneous requests resolve in a single cycle by pointer order; there are no ties.

## Configuration
Macro `DIV_ZERO_BYPASS_EN`:
- Defined: if the winner's divisor is 0 in IDLE, skip the divider. `div_start` stays 0 and the state goes straight to DONE with `result`={BITS{1'b1}}, so `done` is valid at T+1. `grant` and `last` update as normal.
- Undefined: a zero divisor is sent to the divider like any other, and `result` is whatever `div_result` returns.

## Test plan
- Single request: req=0001, dividend 100, divisor 7 → `div_start` pulses once for 1 cycle; then `done`=0001 with `result`=14.
- All four request together, divisor 3, dividends 30/60/90/120 → completion order 0,1,2,3 with results 10,20,30,40; at most one `grant` bit at any time.
- Requester 1 keeps `req` high after `done` while req 2 is also pending → req 2 is served before requester 1 is served again.
- Stale `div_ready`=1 held through LAUNCH/SETTLE → no `done` before the first WAIT cycle.
- Assert `reset` two cycles into WAIT → all outputs 0 immediately, no `done`; the next request from req 0 is served normally.
- Divisor 0 from req 3:
  - With `DIV_ZERO_BYPASS_EN`: `done`=1000 at T+1, `result`=all ones, no `div_start`.
  - Without it: `div_start` pulses and `result`=`div_result`.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that time-shares one SAR divider between NUM_REQ requesters.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor completes at once with an all-ones quotient.
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BITS    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*BITS-1:0] dividendo_in,
    input  logic [NUM_REQ*BITS-1:0] divisor_in,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic [BITS-1:0]         result,
    output logic                    busy,
    output logic                    div_start,
    output logic [BITS-1:0]         div_dividendo,
    output logic [BITS-1:0]         div_divisor,
    input  logic                    div_ready,
    input  logic [BITS-1:0]         div_result
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        lastPtr_q, lastPtr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [BITS-1:0]      result_q, result_d;
    logic                 start_q, start_d;
    logic [BITS-1:0]      dvd_q, dvd_d;
    logic [BITS-1:0]      dvs_q, dvs_d;

    logic [PW-1:0]        scanIdx;
    logic [PW-1:0]        winIdx;
    logic                 winValid;
    logic [BITS-1:0]      selDvd;
    logic [BITS-1:0]      selDvs;
    logic                 zeroBypass;

    // Scan from the farthest candidate back to the nearest so the nearest after lastPtr wins.
    always_comb begin
        scanIdx  = '0;
        winIdx   = '0;
        winValid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scanIdx = PW'((int'(lastPtr_q) + k) % NUM_REQ);
            if (req[scanIdx]) begin
                winIdx   = scanIdx;
                winValid = 1'b1;
            end
        end
    end

    always_comb begin
        selDvd = '0;
        selDvs = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == PW'(i)) begin
                selDvd = dividendo_in[i*BITS +: BITS];
                selDvs = divisor_in[i*BITS +: BITS];
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    assign zeroBypass = (selDvs == '0);
`else
    assign zeroBypass = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lastPtr_d = lastPtr_q;
        grant_d   = grant_q;
        done_d    = done_q;
        result_d  = result_q;
        start_d   = start_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    lastPtr_d = winIdx;
                    grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winIdx;
                    dvd_d     = selDvd;
                    dvs_d     = selDvs;
                    if (zeroBypass) begin
                        result_d = '1;
                        done_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winIdx;
                        state_d  = DONE;
                    end else begin
                        start_d = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                start_d = 1'b0;
                state_d = SETTLE;
            end
            // div_ready may still be high from the previous quotient here.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (div_ready) begin
                    result_d = div_result;
                    done_d   = grant_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = '0;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lastPtr_q <= PW'(NUM_REQ - 1);
            grant_q   <= '0;
            done_q    <= '0;
            result_q  <= '0;
            start_q   <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
        end else begin
            state_q   <= state_d;
            lastPtr_q <= lastPtr_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            result_q  <= result_d;
            start_q   <= start_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
        end
    end

    assign grant         = grant_q;
    assign done          = done_q;
    assign result        = result_q;
    assign busy          = (state_q != IDLE);
    assign div_start     = start_q;
    assign div_dividendo = dvd_q;
    assign div_divisor   = dvs_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter with a behavioural divider stub and
// a modulo-arithmetic round-robin reference model.
module tb_div_share_arbiter;

    localparam int N = 4;
    localparam int B = 64;
    localparam logic [B-1:0] ZERO_Q = 64'hDEAD_BEEF_0BAD_F00D;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*B-1:0]   dvdIn;
    logic [N*B-1:0]   dvsIn;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [B-1:0]     result;
    logic             busy;
    logic             divStart;
    logic [B-1:0]     divDvd;
    logic [B-1:0]     divDvs;
    logic             divReady = 1'b0;
    logic [B-1:0]     divResult = '0;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int cnt = 0;
    int mlast = N - 1;
    logic [B-1:0] mA = '0;
    logic [B-1:0] mB = '0;
    logic [B-1:0] opA [N];
    logic [B-1:0] opB [N];

    always #5 clk = ~clk;

    div_share_arbiter #(.NUM_REQ(N), .BITS(B)) dut (
        .clk(clk), .reset(reset), .req(req),
        .dividendo_in(dvdIn), .divisor_in(dvsIn),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .div_start(divStart), .div_dividendo(divDvd), .div_divisor(divDvs),
        .div_ready(divReady), .div_result(divResult)
    );

    // Divider stub: restarts on div_start, keeps its old ready/quotient until the new one is due.
    always @(posedge clk) begin
        if (divStart) begin
            cnt <= lat;
            mA  <= divDvd;
            mB  <= divDvs;
        end else if (cnt > 1) begin
            cnt      <= cnt - 1;
            divReady <= 1'b0;
        end else if (cnt == 1) begin
            cnt       <= 0;
            divReady  <= 1'b1;
            divResult <= (mB == '0) ? ZERO_Q : mA / mB;
        end
    end

    function automatic int pickNext(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(mlast + k) % N]) return (mlast + k) % N;
        end
        return -1;
    endfunction

    task automatic setOps(input int i, input logic [B-1:0] a, input logic [B-1:0] b);
        opA[i] = a;
        opB[i] = b;
        dvdIn[i*B +: B] = a;
        dvsIn[i*B +: B] = b;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        dvdIn = '0;
        dvsIn = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({grant, done, busy, divStart} !== '0)
            $display("[TB] FAIL reset_ctrl got=%b exp=0", {grant, done, busy, divStart});
        total++;
        if (result !== '0) $display("[TB] FAIL reset_result got=%h exp=0", result);
        total++;
        if ({divDvd, divDvs} !== '0) $display("[TB] FAIL reset_operands got=%h/%h exp=0", divDvd, divDvs);
        bad += ({grant, done, busy, divStart} !== '0) + (result !== '0) + ({divDvd, divDvs} !== '0);
        reset = 1'b0;
        mlast = N - 1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        for (int r = 0; r < 8; r++) begin
            logic [N-1:0] mask;
            logic [N-1:0] pend;
            logic [N-1:0] exp1h;
            int order[$];
            int w;
            int cyc;
            int multi;
            if (r == 0) begin
                mask = '1;
                lat  = 3;
                for (int i = 0; i < N; i++) setOps(i, B'(30 * (i + 1)), B'(3));
            end else begin
                mask = N'($urandom_range(1, (1 << N) - 1));
                lat  = $urandom_range(1, 6);
                for (int i = 0; i < N; i++)
                    setOps(i, {$urandom, $urandom},
                           ($urandom_range(0, 1) == 1) ? B'($urandom_range(1, 1000)) : ({$urandom, $urandom} | 64'd1));
            end
            pend = mask;
            while (pend != '0) begin
                w = pickNext(pend);
                order.push_back(w);
                mlast = w;
                pend[w] = 1'b0;
            end
            @(negedge clk);
            req   = mask;
            cyc   = 0;
            multi = 0;
            while ((order.size() > 0 || busy) && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if ((grant & (grant - 1'b1)) != '0) multi++;
                if (done != '0) begin
                    total++;
                    if (order.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL rr_extra_done round=%0d got=%b exp=none", r, done);
                    end else begin
                        w = order.pop_front();
                        exp1h = '0;
                        exp1h[w] = 1'b1;
                        if (done !== exp1h) begin
                            bad++;
                            $display("[TB] FAIL rr_order round=%0d got=%b exp=%b", r, done, exp1h);
                        end
                        total++;
                        if (result !== opA[w] / opB[w]) begin
                            bad++;
                            $display("[TB] FAIL rr_result round=%0d got=%h exp=%h", r, result, opA[w] / opB[w]);
                        end
                        req[w] = 1'b0;
                    end
                end
            end
            total++;
            if (order.size() != 0) begin
                bad++;
                $display("[TB] FAIL rr_timeout round=%0d got=%0d_pending exp=0", r, order.size());
            end
            total++;
            if (multi != 0) begin
                bad++;
                $display("[TB] FAIL rr_grant_onehot round=%0d got=%0d_cycles exp=0", r, multi);
            end
            req = '0;
        end
    endtask

    task automatic test_single;
        int startCnt = 0;
        int doneCyc = -1;
        int pulses = 0;
        logic [N-1:0] doneVal = '0;
        logic [B-1:0] resVal = '0;
        logic busyT5 = 1'b1;
        lat = 1;
        setOps(0, 64'd100, 64'd7);
        @(negedge clk);
        req = 4'b0001;
        mlast = pickNext(4'b0001);
        @(negedge clk);
        total++;
        if ({grant, busy, divStart} !== {4'b0001, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL single_launch got=%b exp=%b", {grant, busy, divStart}, {4'b0001, 2'b11});
        end
        total++;
        if ({divDvd, divDvs} !== {64'd100, 64'd7}) begin
            bad++;
            $display("[TB] FAIL single_operands got=%0d/%0d exp=100/7", divDvd, divDvs);
        end
        if (divStart) startCnt++;
        req = '0;
        setOps(0, {$urandom, $urandom}, {$urandom, $urandom});
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (divStart) startCnt++;
            if (done != '0) begin
                pulses++;
                if (doneCyc < 0) begin
                    doneCyc = c;
                    doneVal = done;
                    resVal  = result;
                end
            end
            if (c == 5) busyT5 = busy;
        end
        total++;
        if (doneCyc != 3 + lat) begin bad++; $display("[TB] FAIL single_done_cycle got=%0d exp=%0d", doneCyc, 3 + lat); end
        total++;
        if (doneVal !== 4'b0001) begin bad++; $display("[TB] FAIL single_done got=%b exp=0001", doneVal); end
        total++;
        if (resVal !== 64'd14) begin bad++; $display("[TB] FAIL single_result got=%0d exp=14", resVal); end
        total++;
        if (pulses != 1 || startCnt != 1) begin
            bad++;
            $display("[TB] FAIL single_pulses got=done%0d/start%0d exp=1/1", pulses, startCnt);
        end
        total++;
        if (busyT5 !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b exp=0", busyT5); end
        total++;
        if (divDvd !== 64'd100) begin bad++; $display("[TB] FAIL single_hold got=%0d exp=100", divDvd); end
    endtask

    task automatic test_stale;
        int doneCyc = -1;
        logic [N-1:0] doneVal = '0;
        logic [B-1:0] resVal = '0;
        lat = 4;
        setOps(2, 64'd999, 64'd10);
        @(negedge clk);
        req = 4'b0100;
        mlast = pickNext(4'b0100);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done != '0 && doneCyc < 0) begin
                doneCyc = c;
                doneVal = done;
                resVal  = result;
                req     = '0;
            end
        end
        total++;
        if (doneCyc != 3 + lat) begin bad++; $display("[TB] FAIL stale_done_cycle got=%0d exp=%0d", doneCyc, 3 + lat); end
        total++;
        if (doneVal !== 4'b0100 || resVal !== 64'd99) begin
            bad++;
            $display("[TB] FAIL stale_result got=%b/%0d exp=0100/99", doneVal, resVal);
        end
        req = '0;
    endtask

    task automatic test_back_to_back;
        int need [N];
        logic [N-1:0] pend;
        logic [N-1:0] exp1h;
        int served = 0;
        int cyc = 0;
        int w;
        lat = 2;
        for (int i = 0; i < N; i++) need[i] = 0;
        need[1] = 2;
        need[2] = 1;
        setOps(1, 64'd77, 64'd7);
        setOps(2, 64'd50, 64'd5);
        @(negedge clk);
        req = 4'b0110;
        while ((served < 3 || busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                pend = '0;
                for (int i = 0; i < N; i++) pend[i] = (need[i] > 0);
                w = pickNext(pend);
                mlast = w;
                exp1h = '0;
                if (w >= 0) exp1h[w] = 1'b1;
                total++;
                if (done !== exp1h || w < 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_order served=%0d got=%b exp=%b", served, done, exp1h);
                end else begin
                    total++;
                    if (result !== opA[w] / opB[w]) begin
                        bad++;
                        $display("[TB] FAIL b2b_result got=%0d exp=%0d", result, opA[w] / opB[w]);
                    end
                    need[w]--;
                    if (need[w] == 0) req[w] = 1'b0;
                end
                served++;
            end
        end
        total++;
        if (served != 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=3", served); end
        req = '0;
    endtask

    task automatic test_reset_mid_op;
        int doneCyc = -1;
        int stray = 0;
        logic [N-1:0] doneVal = '0;
        logic [B-1:0] resVal = '0;
        lat = 20;
        setOps(0, 64'd500, 64'd5);
        @(negedge clk);
        req = 4'b0001;
        repeat (5) @(negedge clk);
        req = '0;
        #1 reset = 1'b1;
        #1;
        total++;
        if ({grant, done, busy, divStart} !== '0 || result !== '0 || {divDvd, divDvs} !== '0) begin
            bad++;
            $display("[TB] FAIL midop_reset got=%b/%h/%h exp=0", {grant, done, busy, divStart}, result, divDvd);
        end
        @(negedge clk);
        reset = 1'b0;
        mlast = N - 1;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        total++;
        if (divStart !== 1'b1) begin bad++; $display("[TB] FAIL launch_start got=%b exp=1", divStart); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({divStart, grant} !== '0) begin bad++; $display("[TB] FAIL launch_reset got=%b exp=0", {divStart, grant}); end
        @(negedge clk);
        reset = 1'b0;
        mlast = N - 1;
        repeat (4) begin
            @(negedge clk);
            if (done != '0) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("[TB] FAIL reset_no_done got=%0d exp=0", stray); end
        lat = 2;
        req = 4'b0001;
        mlast = pickNext(4'b0001);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done != '0 && doneCyc < 0) begin
                doneCyc = c;
                doneVal = done;
                resVal  = result;
                req     = '0;
            end
        end
        total++;
        if (doneCyc != 3 + lat || doneVal !== 4'b0001 || resVal !== 64'd100) begin
            bad++;
            $display("[TB] FAIL after_reset got=%0d/%b/%0d exp=%0d/0001/100", doneCyc, doneVal, resVal, 3 + lat);
        end
        req = '0;
    endtask

    task automatic test_zero_divisor;
        int startCnt = 0;
        int doneCyc = -1;
        logic [N-1:0] doneVal = '0;
        logic [B-1:0] resVal = '0;
        int expCyc;
        int expStart;
        logic [B-1:0] expRes;
        lat = 2;
`ifdef DIV_ZERO_BYPASS_EN
        expCyc   = 1;
        expStart = 0;
        expRes   = '1;
`else
        expCyc   = 3 + lat;
        expStart = 1;
        expRes   = ZERO_Q;
`endif
        setOps(3, 64'd12345, 64'd0);
        @(negedge clk);
        req = 4'b1000;
        mlast = pickNext(4'b1000);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (divStart) startCnt++;
            if (done != '0 && doneCyc < 0) begin
                doneCyc = c;
                doneVal = done;
                resVal  = result;
                req     = '0;
            end
        end
        total++;
        if (doneCyc != expCyc) begin bad++; $display("[TB] FAIL zero_done_cycle got=%0d exp=%0d", doneCyc, expCyc); end
        total++;
        if (doneVal !== 4'b1000) begin bad++; $display("[TB] FAIL zero_done got=%b exp=1000", doneVal); end
        total++;
        if (resVal !== expRes) begin bad++; $display("[TB] FAIL zero_result got=%h exp=%h", resVal, expRes); end
        total++;
        if (startCnt != expStart) begin bad++; $display("[TB] FAIL zero_start got=%0d exp=%0d", startCnt, expStart); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_stale();
        test_back_to_back();
        test_reset_mid_op();
        test_zero_divisor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
